// File: rtl/apb_src_pkg.sv
// Shared types for the APB source-channel master: FSM state and queued command layout.
package apb_src_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_cmd_t;
endpackage

// File: rtl/apb_cmd_queue.sv
// QDEPTH-entry command FIFO, write-to-read latency 1 cycle; push ignored when full, pop ignored when empty.
module apb_cmd_queue
  import apb_src_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  apb_cmd_t push_data,
  input  logic     pop,
  output apb_cmd_t pop_data,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(QDEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  apb_cmd_t    mem [QDEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/apb_src_master.sv
// Command stream to APB master: accept->psel 1 cycle, ->penable 2, ->rsp 3 + wait states.
// cmd_ready is the registered !full; a new transfer starts only while the response slot is free.
module apb_src_master #(
  parameter int ADDR_W  = apb_src_pkg::ADDR_W,
  parameter int DATA_W  = apb_src_pkg::DATA_W,
  parameter int TIMEOUT = 16,
  parameter int QDEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);
  import apb_src_pkg::*;

  localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  apb_state_e    state;
  logic [CW-1:0] cnt;
  apb_cmd_t      q_in;
  apb_cmd_t      q_out;
  logic          q_full;
  logic          q_empty;
  logic          start;
  logic          done_ok;
  logic          done_to;

  assign q_in.write = cmd_write;
  assign q_in.addr  = cmd_addr;
  assign q_in.wdata = cmd_wdata;

  apb_cmd_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid),
    .push_data (q_in),
    .pop       (start),
    .pop_data  (q_out),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign cmd_ready = !q_full;
  // Gating on a free response slot means a completion never collides with a held response.
  assign start     = (state == IDLE) && !q_empty && (!rsp_valid || rsp_ready);
  assign done_ok   = (state == ACCESS) && pready;
  assign done_to   = (state == ACCESS) && !pready && (TIMEOUT != 0) && (cnt == TO_LAST);
  assign psel      = (state != IDLE);
  assign penable   = (state == ACCESS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SETUP;
            pwrite <= q_out.write;
            paddr  <= q_out.addr;
            pwdata <= q_out.wdata;
            cnt    <= '0;
          end
        end
        SETUP:   state <= ACCESS;
        ACCESS: begin
          if (done_ok || done_to) state <= IDLE;
          else                    cnt   <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (done_ok || done_to) begin
        rsp_valid <= 1'b1;
        rsp_err   <= done_to;
        rsp_rdata <= (done_ok && !pwrite) ? prdata : '0;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_apb_src_master.sv
// Bench for apb_src_master: directed vector table, hand sequences and random traffic vs a queue-based model.
module tb_apb_src_master;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        pwrite, psel, penable, pready;
  logic [31:0] paddr, pwdata, prdata;

  always #5 clk = ~clk;

  apb_src_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .QDEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .pwrite(pwrite), .psel(psel), .penable(penable), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  typedef struct { logic write; logic [31:0] addr; logic [31:0] wdata; } cmd_s;
  typedef struct { logic [31:0] rdata; logic err; } rsp_s;
  typedef struct {
    logic write; logic [31:0] addr; logic [31:0] wdata; int ws; logic [31:0] rd;
    logic [31:0] exp_rdata; logic exp_err; int exp_acc;
  } vec_t;

  cmd_s        exp_q[$];
  rsp_s        rsp_q[$];
  int          ws_q[$];
  logic [31:0] rdv_q[$];
  cmd_s        cur_cmd, act_cmd;
  int          cur_ws, exp_acc, acc_len, last_acc_len;
  logic [31:0] cur_rd;
  int          checks = 0, errors = 0, cyc = 0, hs_cyc = 0, n_setup = 0, rr_mode = 0;
  logic        acc_flag = 1'b0, prev_psel = 1'b0;
  vec_t        tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: every accepted command appears once on the bus in order; response follows slave outcome.
  task automatic monitor();
    rsp_s e;
    if (!psel) chk("penable_without_psel", 32'(penable), 32'd0);
    if (psel && !penable) begin
      n_setup++;
      chk("setup_after_idle", 32'(prev_psel), 32'd0);
      chk("setup_rsp_slot_free", 32'(rsp_valid), 32'd0);
      chk("setup_cmd_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        act_cmd = exp_q.pop_front();
        chk("setup_paddr", paddr, act_cmd.addr);
        chk("setup_pwdata", pwdata, act_cmd.wdata);
        chk("setup_pwrite", 32'(pwrite), 32'(act_cmd.write));
        if (ws_q.size() > 0) cur_ws = ws_q.pop_front();
        else if ($urandom_range(0, 7) == 0) cur_ws = 20;
        else cur_ws = $urandom_range(0, 3);
        if (rdv_q.size() > 0) cur_rd = rdv_q.pop_front();
        else cur_rd = $urandom;
        e.err   = (cur_ws >= TMO);
        e.rdata = (e.err || act_cmd.write) ? 32'd0 : cur_rd;
        exp_acc = e.err ? TMO : cur_ws + 1;
        rsp_q.push_back(e);
      end
      acc_len = 0;
    end else if (psel && penable) begin
      chk("access_after_setup", 32'(prev_psel), 32'd1);
      chk("access_paddr_stable", paddr, act_cmd.addr);
      chk("access_pwdata_stable", pwdata, act_cmd.wdata);
      chk("access_pwrite_stable", 32'(pwrite), 32'(act_cmd.write));
      acc_len++;
    end else if (prev_psel) begin
      last_acc_len = acc_len;
      chk("access_len", acc_len, exp_acc);
    end
    prev_psel = psel;
  endtask

  task automatic slave();
    if (psel && penable) begin
      pready = (acc_len - 1 == cur_ws);
      prdata = pready ? cur_rd : $urandom;
    end else begin
      pready = 1'($urandom_range(0, 1));
      prdata = $urandom;
    end
  endtask

  task automatic tick();
    logic hs, rr, hold, err_s;
    logic [31:0] rd_s;
    rsp_s e;
    hs    = cmd_valid && cmd_ready;
    rr    = rsp_valid && rsp_ready;
    hold  = rsp_valid && !rsp_ready;
    rd_s  = rsp_rdata;
    err_s = rsp_err;
    @(posedge clk); #1;
    cyc++;
    if (hs) begin
      exp_q.push_back(cur_cmd);
      cmd_valid = 1'b0;
      acc_flag  = 1'b1;
      hs_cyc    = cyc;
    end
    if (rr) begin
      chk("rsp_expected", 32'(rsp_q.size() > 0), 32'd1);
      if (rsp_q.size() > 0) begin
        e = rsp_q.pop_front();
        chk("rsp_rdata", rd_s, e.rdata);
        chk("rsp_err", 32'(err_s), 32'(e.err));
      end
    end
    if (hold) begin
      chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_hold_rdata", rsp_rdata, rd_s);
      chk("rsp_hold_err", 32'(rsp_err), 32'(err_s));
    end
    monitor();
    slave();
    if (rr_mode == 0)      rsp_ready = 1'b1;
    else if (rr_mode == 1) rsp_ready = 1'b0;
    else                   rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic offer(input logic w, input logic [31:0] a, input logic [31:0] d);
    cur_cmd.write = w; cur_cmd.addr = a; cur_cmd.wdata = d;
    cmd_write = w; cmd_addr = a; cmd_wdata = d;
    cmd_valid = 1'b1;
    acc_flag  = 1'b0;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    offer(w, a, d);
    for (int i = 0; i < 300 && !acc_flag; i++) tick();
    chk("cmd_accepted", 32'(acc_flag), 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 300 && !rsp_valid; i++) tick();
    chk("rsp_arrived", 32'(rsp_valid), 32'd1);
  endtask

  task automatic drain();
    rr_mode = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2000 && (exp_q.size() > 0 || rsp_q.size() > 0 || psel || rsp_valid); i++) tick();
    chk("drained", exp_q.size() + rsp_q.size(), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0,   32'h1111_2222, 32'h0, 1'b0, 1};
    tbl[1] = '{1'b0, 32'h0000_0014, 32'h0,         3,   32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 4};
    tbl[2] = '{1'b0, 32'h0000_0020, 32'h0,         100, 32'h7777_7777, 32'h0, 1'b1, TMO};
    tbl[3] = '{1'b1, 32'h0000_0024, 32'h1234_5678, 100, 32'h0,         32'h0, 1'b1, TMO};
    tbl[4] = '{1'b0, 32'h0000_0028, 32'h0,         15,  32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, TMO};
    tbl[5] = '{1'b0, 32'h0000_002C, 32'h0,         0,   32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0; prdata = '0;
    #12;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) tick();

    // Directed vectors: latency, wait states, timeout boundary and last-allowed pready.
    rr_mode = 0; rsp_ready = 1'b1;
    foreach (tbl[i]) begin
      ws_q.push_back(tbl[i].ws);
      rdv_q.push_back(tbl[i].rd);
      send(tbl[i].write, tbl[i].addr, tbl[i].wdata);
      chk("t_idle_at_accept", 32'(psel), 32'd0);
      tick();
      chk("t_setup_psel", 32'(psel), 32'd1);
      chk("t_setup_penable", 32'(penable), 32'd0);
      tick();
      chk("t_access_penable", 32'(penable), 32'd1);
      wait_rsp();
      chk("t_rdata", rsp_rdata, tbl[i].exp_rdata);
      chk("t_err", 32'(rsp_err), 32'(tbl[i].exp_err));
      chk("t_psel_dropped", 32'(psel), 32'd0);
      chk("t_acc_len", last_acc_len, tbl[i].exp_acc);
      chk("t_latency", cyc - hs_cyc, 2 + tbl[i].exp_acc);
      tick();
    end

    // Queue fills while the response slot is blocked; the next transfer waits for consumption.
    rr_mode = 1; rsp_ready = 1'b0; n_setup = 0;
    ws_q.push_back(1); ws_q.push_back(0); ws_q.push_back(2); ws_q.push_back(1);
    send(1'b1, 32'h100, 32'h1111_1111);
    send(1'b0, 32'h104, 32'h0);
    send(1'b1, 32'h108, 32'h3333_3333);
    chk("bb_full_cmd_ready", 32'(cmd_ready), 32'd0);
    offer(1'b0, 32'h10C, 32'h0);
    for (int i = 0; i < 25; i++) tick();
    chk("bb_still_full", 32'(cmd_ready), 32'd0);
    chk("bb_not_accepted", 32'(acc_flag), 32'd0);
    chk("bb_one_transfer", n_setup, 32'd1);
    chk("bb_rsp_held", 32'(rsp_valid), 32'd1);
    rr_mode = 0; rsp_ready = 1'b1;
    for (int i = 0; i < 300 && !acc_flag; i++) tick();
    chk("bb_fourth_accepted", 32'(acc_flag), 32'd1);
    cmd_valid = 1'b0;
    drain();
    chk("bb_all_transfers", n_setup, 32'd4);

    // Random traffic with random response backpressure and occasional timeouts.
    rr_mode = 2;
    for (int i = 0; i < 40; i++) send(1'($urandom_range(0, 1)), $urandom & 32'h0000_0FFC, $urandom);
    drain();

    // Reset during ACCESS with two commands still queued.
    ws_q.push_back(50); ws_q.push_back(0); ws_q.push_back(0);
    send(1'b0, 32'h200, 32'h0);
    send(1'b1, 32'h204, 32'h4444_4444);
    send(1'b0, 32'h208, 32'h0);
    for (int i = 0; i < 10 && !penable; i++) tick();
    tick(); tick();
    chk("rr_in_access", 32'(penable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_psel", 32'(psel), 32'd0);
    chk("rr_penable", 32'(penable), 32'd0);
    chk("rr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rr_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rr_paddr", paddr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete(); rsp_q.delete(); ws_q.delete(); rdv_q.delete();
    prev_psel = 1'b0; acc_len = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_no_rsp", 32'(rsp_valid), 32'd0);
      chk("rr_no_psel", 32'(psel), 32'd0);
    end
    ws_q.push_back(0);
    send(1'b1, 32'h300, 32'hFEED_FACE);
    wait_rsp();
    chk("rr_after_err", 32'(rsp_err), 32'd0);
    chk("rr_after_rdata", rsp_rdata, 32'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
